// File: rtl/timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// timer_pkg : shared widths and FSM state type for the prescaled timers
// Rev 1.0
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam int CNT_W = 16;
  localparam int PSC_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/psc_divider.sv
`default_nettype none
// ---------------------------------------------------------------------------
// psc_divider : prescaler, asserts tick_en_o once every psc_i+1 enabled cycles
// Rev 1.0
// ---------------------------------------------------------------------------
module psc_divider #(
  parameter int PSC_W = timer_pkg::PSC_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [PSC_W-1:0] psc_i,
  output logic             tick_en_o
);

  logic [PSC_W-1:0] prescaler_q;
  logic [PSC_W-1:0] prescaler_d;

  // >= rather than == so a psc lowered below the running count still fires
  assign tick_en_o = en_i && (prescaler_q >= psc_i);

  always_comb begin
    prescaler_d = prescaler_q;
    if (clr_i || tick_en_o) begin
      prescaler_d = '0;
    end else if (en_i) begin
      prescaler_d = prescaler_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      prescaler_q <= '0;
    end else begin
      prescaler_q <= prescaler_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prescaled_up_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// prescaled_up_counter : 0..top up-counter with prescaler, one-shot and compare
// Rev 1.0
// ---------------------------------------------------------------------------
module prescaled_up_counter #(
  parameter int CNT_W = timer_pkg::CNT_W,
  parameter int PSC_W = timer_pkg::PSC_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [PSC_W-1:0] psc_i,
  input  logic [CNT_W-1:0] top_i,
  input  logic             one_shot_i,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic [CNT_W-1:0] counter_o,
  output logic             tick_o,
  output logic             done_o,
  output logic             cmp_out_o,
  output logic             busy_o
);

  import timer_pkg::*;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] top_shadow_q, top_shadow_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             cmp_q;
  logic             busy_q;

  logic w_tick_en;
  logic w_div_en;
  logic w_div_clr;
  logic w_at_top;

  assign w_div_en  = (state_q == RUN) && en_i;
  assign w_div_clr = restart_i || (state_q != RUN);
  assign w_at_top  = (counter_q == top_shadow_q);

  psc_divider #(
    .PSC_W (PSC_W)
  ) u_psc_divider (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .en_i      (w_div_en),
    .clr_i     (w_div_clr),
    .psc_i     (psc_i),
    .tick_en_o (w_tick_en)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (restart_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    if (en_i) state_d = RUN;
        RUN:     if (w_tick_en && w_at_top && one_shot_i) state_d = HOLD;
        default: state_d = state_q;
      endcase
    end
  end

  // restart wins over a coincident terminal tick, so no done on that edge
  always_comb begin
    counter_d    = counter_q;
    top_shadow_d = top_shadow_q;
    tick_d       = 1'b0;
    done_d       = 1'b0;
    if (restart_i) begin
      counter_d    = '0;
      top_shadow_d = top_i;
    end else if (state_q == IDLE) begin
      counter_d = '0;
      if (en_i) top_shadow_d = top_i;
    end else if (w_tick_en) begin
      tick_d = 1'b1;
      if (w_at_top) begin
        done_d = 1'b1;
        if (!one_shot_i) begin
          counter_d    = '0;
          top_shadow_d = top_i;
        end
      end else begin
        counter_d = counter_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      counter_q    <= '0;
      top_shadow_q <= '0;
      tick_q       <= 1'b0;
      done_q       <= 1'b0;
      cmp_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      top_shadow_q <= top_shadow_d;
      tick_q       <= tick_d;
      done_q       <= done_d;
      cmp_q        <= (counter_q >= cmp_i);
      busy_q       <= (state_d == RUN);
    end
  end

  assign counter_o = counter_q;
  assign tick_o    = tick_q;
  assign done_o    = done_q;
  assign cmp_out_o = cmp_q;
  assign busy_o    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_prescaled_up_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_prescaled_up_counter : scoreboard bench with a behavioural timer model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_prescaled_up_counter;

  localparam int CNT_W = 16;
  localparam int PSC_W = 5;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic             clk = 1'b0;
  logic             reset_i = 1'b1;
  logic             en_i = 1'b0;
  logic [PSC_W-1:0] psc_i = '0;
  logic [CNT_W-1:0] top_i = '0;
  logic             one_shot_i = 1'b0;
  logic             restart_i = 1'b0;
  logic [CNT_W-1:0] cmp_i = '0;
  logic [CNT_W-1:0] counter_o;
  logic             tick_o;
  logic             done_o;
  logic             cmp_out_o;
  logic             busy_o;

  always #5 clk = ~clk;

  prescaled_up_counter #(
    .CNT_W (CNT_W),
    .PSC_W (PSC_W)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .psc_i      (psc_i),
    .top_i      (top_i),
    .one_shot_i (one_shot_i),
    .restart_i  (restart_i),
    .cmp_i      (cmp_i),
    .counter_o  (counter_o),
    .tick_o     (tick_o),
    .done_o     (done_o),
    .cmp_out_o  (cmp_out_o),
    .busy_o     (busy_o)
  );

  typedef struct {
    int cnt;
    bit tick;
    bit done;
    bit cmp_out;
    bit busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // stimulus knobs
  int g_psc = 0, g_top = 0, g_cmp = 0;
  bit g_en = 1'b0, g_os = 1'b0;

  // behavioural model: mode, count, shadowed top, enabled cycles since last tick
  int m_mode = M_IDLE, m_cnt = 0, m_top = 0, m_pre = 0;

  task automatic step(input bit r, input bit rs);
    exp_t x;
    @(negedge clk);
    reset_i    = r;
    en_i       = g_en;
    psc_i      = PSC_W'(g_psc);
    top_i      = CNT_W'(g_top);
    one_shot_i = g_os;
    restart_i  = rs;
    cmp_i      = CNT_W'(g_cmp);
    x.tick = 1'b0; x.done = 1'b0; x.cmp_out = 1'b0;
    if (r) begin
      m_mode = M_IDLE; m_cnt = 0; m_top = 0; m_pre = 0;
    end else begin
      x.cmp_out = (m_cnt >= g_cmp);
      if (rs) begin
        m_cnt = 0; m_pre = 0; m_top = g_top; m_mode = M_RUN;
      end else if (m_mode == M_IDLE) begin
        if (g_en) begin
          m_mode = M_RUN; m_top = g_top; m_pre = 0;
        end
      end else if (m_mode == M_RUN && g_en) begin
        if (m_pre >= g_psc) begin
          m_pre  = 0;
          x.tick = 1'b1;
          if (m_cnt == m_top) begin
            x.done = 1'b1;
            if (g_os) m_mode = M_HOLD;
            else begin
              m_cnt = 0; m_top = g_top;
            end
          end else begin
            m_cnt = m_cnt + 1;
          end
        end else begin
          m_pre = m_pre + 1;
        end
      end
    end
    x.cnt  = m_cnt;
    x.busy = (m_mode == M_RUN);
    exp_q.push_back(x);
  endtask

  // monitor: one expectation per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (counter_o !== CNT_W'(e.cnt) || tick_o !== e.tick || done_o !== e.done ||
            cmp_out_o !== e.cmp_out || busy_o !== e.busy) begin
          n_bad++;
          $display("FAIL outputs @%0t: got cnt=%0d tick=%b done=%b cmp=%b busy=%b, want cnt=%0d tick=%b done=%b cmp=%b busy=%b",
                   $time, counter_o, tick_o, done_o, cmp_out_o, busy_o,
                   e.cnt, e.tick, e.done, e.cmp_out, e.busy);
        end
      end
    end
  end

  initial begin
    bit hit;
    bit term;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // free-running period, then top lowered mid-period
    g_psc = 1; g_top = 10; g_en = 1'b1;
    repeat (50) step(1'b0, 1'b0);
    g_top = 5;
    repeat (40) step(1'b0, 1'b0);

    // pause at counter 4
    for (int i = 0; i < 100 && !(m_cnt == 4 && m_pre == 0); i++) step(1'b0, 1'b0);
    g_en = 1'b0;
    repeat (7) step(1'b0, 1'b0);
    g_en = 1'b1;
    repeat (10) step(1'b0, 1'b0);

    // one-shot: hold, en ignored, restart resumes
    g_psc = 0; g_top = 3; g_os = 1'b1;
    step(1'b0, 1'b1);
    repeat (8) step(1'b0, 1'b0);
    g_en = 1'b0;
    repeat (2) step(1'b0, 1'b0);
    g_en = 1'b1;
    repeat (2) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    g_os = 1'b0;

    // restart colliding with the terminal tick
    g_psc = 2; g_top = 4; hit = 1'b0;
    for (int i = 0; i < 60; i++) begin
      term = (m_mode == M_RUN) && g_en && (m_pre >= g_psc) && (m_cnt == m_top);
      step(1'b0, term && !hit);
      if (term) hit = 1'b1;
    end

    // reset mid-count
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);

    // compare threshold
    g_cmp = 6; g_top = 10; g_psc = 0;
    step(1'b0, 1'b1);
    repeat (30) step(1'b0, 1'b0);

    // top of zero, continuous then one-shot
    g_top = 0; g_psc = 1;
    step(1'b0, 1'b1);
    repeat (10) step(1'b0, 1'b0);
    g_os = 1'b1;
    step(1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0);
    g_os = 1'b0;

    repeat (2000) begin
      g_en  = ($urandom % 8) != 0;
      g_psc = $urandom % 4;
      g_top = $urandom % 8;
      g_cmp = $urandom % 9;
      g_os  = ($urandom % 6) == 0;
      step(($urandom % 97) == 0, ($urandom % 23) == 0);
    end

    repeat (2) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
